// File: rtl/grant_ctrl_pkg.sv
// Shared types and sizes for the grant controller.
package grant_ctrl_pkg;

  localparam int unsigned NumReq = 8;
  localparam int unsigned CntW   = 4;
  localparam int unsigned IdxW   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRelease
  } state_e;

  // Binary index of a one-hot vector; zero for an all-zero vector.
  function automatic logic [IdxW-1:0] onehot_to_idx(input logic [NumReq-1:0] onehot);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (onehot[i]) idx = IdxW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/grant_ctrl_ps8.sv
// Eight-input fixed-priority selector; bit 7 wins, output is one-hot or zero.
module grant_ctrl_ps8
  import grant_ctrl_pkg::*;
(
  input  logic [NumReq-1:0] i_req,
  input  logic              i_en,
  output logic [NumReq-1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    // Ascending scan so the highest set bit overwrites lower ones.
    for (int i = 0; i < NumReq; i++) begin
      if (i_en && i_req[i]) begin
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grant_ctrl.sv
// Priority grant controller: IDLE/HOLD/RELEASE FSM with bounded hold time and
// a one-shot mask on the requester released by timeout.
module grant_ctrl
  import grant_ctrl_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NumReq-1:0] i_req,
  input  logic              i_en,
  input  logic              i_done,
  output logic [NumReq-1:0] o_gnt,
  output logic [IdxW-1:0]   o_gnt_idx,
  output logic              o_busy,
  output logic              o_timeout
);

  localparam logic [CntW-1:0] MaxHoldC = CntW'(MAX_HOLD);

  state_e            r_state;
  logic [NumReq-1:0] r_gnt;
  logic [NumReq-1:0] r_mask;
  logic [CntW-1:0]   r_cnt;
  logic              r_busy;
  logic              r_timeout;

  logic [NumReq-1:0] w_sel;
  logic              w_sel_en;
  logic              w_holder_req;
  logic              w_exit;

  assign w_sel_en     = i_en && (r_state == StIdle);
  assign w_holder_req = |(i_req & r_gnt);
  assign w_exit       = i_done || !w_holder_req || (r_cnt == MaxHoldC);

  grant_ctrl_ps8 u_ps8 (
    .i_req (i_req & ~r_mask),
    .i_en  (w_sel_en),
    .o_gnt (w_sel)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_gnt     <= '0;
      r_mask    <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // The mask only ever survives a single IDLE cycle.
          r_mask <= '0;
          r_gnt  <= w_sel;
          if (|w_sel) begin
            r_cnt   <= CntW'(1);
            r_busy  <= 1'b1;
            r_state <= StHold;
          end
        end
        StHold: begin
          if (w_exit) begin
            r_state <= StRelease;
            r_gnt   <= '0;
            r_cnt   <= '0;
            if (!i_done && w_holder_req) begin
              r_timeout <= 1'b1;
              r_mask    <= r_gnt;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StRelease: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_gnt_idx = onehot_to_idx(r_gnt);
  assign o_busy    = r_busy;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_grant_ctrl.sv
// Scoreboard bench for grant_ctrl with MAX_HOLD=4 and directed vectors.
module tb_grant_ctrl;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       busy;
    logic       tmo;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       en;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       tmo;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  grant_ctrl #(
    .MAX_HOLD (4)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_req     (req),
    .i_en      (en),
    .i_done    (done),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx),
    .o_busy    (busy),
    .o_timeout (tmo)
  );

  function automatic logic [2:0] enc(input logic [7:0] g);
    case (g)
      8'h02:   return 3'd1;
      8'h04:   return 3'd2;
      8'h08:   return 3'd3;
      8'h10:   return 3'd4;
      8'h20:   return 3'd5;
      8'h40:   return 3'd6;
      8'h80:   return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    n_chk++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Apply inputs for one cycle; queue what the outputs must be after the edge.
  task automatic step(input logic r, input logic [7:0] rq, input logic e, input logic d,
                      input logic [7:0] eg, input logic eb, input logic et);
    exp_t x;
    rst  = r;
    req  = rq;
    en   = e;
    done = d;
    x.gnt  = eg;
    x.idx  = enc(eg);
    x.busy = eb;
    x.tmo  = et;
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are presented every cycle, popped just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt", gnt, e.gnt);
        chk("gnt_idx", {5'd0, gnt_idx}, {5'd0, e.idx});
        chk("busy", {7'd0, busy}, {7'd0, e.busy});
        chk("timeout", {7'd0, tmo}, {7'd0, e.tmo});
      end
      chk("onehot0", {7'd0, $onehot0(gnt)}, 8'd1);
      chk("idx_consistent", {5'd0, gnt_idx}, {5'd0, enc(gnt)});
    end
  end

  initial begin
    int guard;
    // Reset, including reset overriding every other input.
    step(1, 8'h00, 0, 0, 8'h00, 0, 0);
    step(1, 8'hFF, 1, 1, 8'h00, 0, 0);
    // Scenario 1: priority pick, one-cycle latency.
    step(0, 8'h24, 1, 0, 8'h20, 1, 0);
    // Scenario 2: grant held against req/en changes, then done.
    step(0, 8'hFF, 0, 0, 8'h20, 1, 0);
    step(0, 8'hFF, 1, 1, 8'h00, 1, 0);
    step(0, 8'hFF, 1, 1, 8'h00, 0, 0);
    step(0, 8'hFF, 1, 1, 8'h80, 1, 0);
    step(0, 8'hFF, 0, 1, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 0);
    // Scenario 3: forced release after 4 cycles, holder masked once.
    step(0, 8'h03, 1, 0, 8'h02, 1, 0);
    step(0, 8'h03, 0, 0, 8'h02, 1, 0);
    step(0, 8'h03, 0, 0, 8'h02, 1, 0);
    step(0, 8'h03, 0, 0, 8'h02, 1, 0);
    step(0, 8'h03, 0, 0, 8'h00, 1, 1);
    step(0, 8'h03, 1, 0, 8'h00, 0, 0);
    step(0, 8'h03, 1, 0, 8'h01, 1, 0);
    // Scenario 4: holder request drops mid-hold.
    step(0, 8'h03, 0, 0, 8'h01, 1, 0);
    step(0, 8'h02, 0, 0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 0);
    // Done coincident with expiry: no timeout, no mask afterwards.
    step(0, 8'h01, 1, 0, 8'h01, 1, 0);
    step(0, 8'h01, 0, 0, 8'h01, 1, 0);
    step(0, 8'h01, 0, 0, 8'h01, 1, 0);
    step(0, 8'h01, 0, 0, 8'h01, 1, 0);
    step(0, 8'h01, 0, 1, 8'h00, 1, 0);
    step(0, 8'h01, 1, 0, 8'h00, 0, 0);
    step(0, 8'h01, 1, 0, 8'h01, 1, 0);
    step(0, 8'h01, 0, 1, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 0);
    // Only request masked: one empty IDLE arbitration, then granted again.
    step(0, 8'h04, 1, 0, 8'h04, 1, 0);
    step(0, 8'h04, 0, 0, 8'h04, 1, 0);
    step(0, 8'h04, 0, 0, 8'h04, 1, 0);
    step(0, 8'h04, 0, 0, 8'h04, 1, 0);
    step(0, 8'h04, 0, 0, 8'h00, 1, 1);
    step(0, 8'h04, 1, 0, 8'h00, 0, 0);
    step(0, 8'h04, 1, 0, 8'h00, 0, 0);
    step(0, 8'h04, 1, 0, 8'h04, 1, 0);
    // Scenario 5: reset in the second hold cycle aborts with no pulse.
    step(0, 8'h04, 0, 0, 8'h04, 1, 0);
    step(1, 8'h04, 1, 0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 0);
    // Scenario 6: arbitration disabled, then enabled with no request.
    for (int i = 0; i < 10; i++) step(0, 8'hFF, 0, 0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0, 8'h00, 0, 0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    n_chk++;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
